reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DATA_W, default 8: register and data width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2^ADDR_W registers.
REQ-003 Parameter REG_READ, default 0: 0 = combinational read ports; 1 = registered read ports (1-cycle latency).
REQ-004 Parameter ZERO_REG, default 0: 1 = register 0 is hardwired to zero.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 ra  input  ADDR_W  read port A address.
REQ-008 rb  input  ADDR_W  read port B address.
REQ-009 wa  input  ADDR_W  write address.
REQ-010 wd  input  DATA_W  write data.
REQ-011 we  input  1  write enable.
REQ-012 clr_req  input  1  request to bulk-clear all registers.
REQ-013 read_a  output  DATA_W  port A read data.
REQ-014 read_b  output  DATA_W  port B read data.
REQ-015 clr_busy  output  1  high while a clear sweep is in progress.
REQ-016 clr_done  output  1  one-cycle pulse when a sweep completes.

Function
REQ-017 A write SHALL occur on a rising edge with we=1 and clr_busy=0, storing wd at mem[wa]; with clr_busy=1 the write SHALL be ignored.
REQ-018 REG_READ=0: read_a = mem[ra] and read_b = mem[rb] SHALL be combinational; a write becomes visible only after its edge, with no bypass.
REQ-019 REG_READ=1: read_a/read_b SHALL register mem[ra]/mem[rb] on each edge; if a write accepted on that same edge targets the read address, the register SHALL capture wd (write-to-read bypass).
REQ-020 ZERO_REG=1: any read of address 0 SHALL return 0, and writes to address 0 SHALL be discarded.
REQ-021 Both ports SHALL read independently, including the case ra=rb.
REQ-022 The clear FSM SHALL have two states, IDLE and CLEAR, plus an ADDR_W-bit sweep counter.
REQ-023 IDLE->CLEAR SHALL occur on the edge where clr_req=1 is sampled (edge T0); the counter SHALL load 0 and clr_busy SHALL go high after T0.
REQ-024 In CLEAR, edge T(k+1) SHALL write 0 to mem[k] and increment the counter, for k = 0..DEPTH-1.
REQ-025 At edge T(DEPTH), the counter SHALL wrap from DEPTH-1 and the FSM SHALL return to IDLE; clr_busy SHALL drop and clr_done SHALL be high for exactly the following cycle.
REQ-026 clr_req asserted while clr_busy=1 SHALL be ignored, with no restart or queuing.
REQ-027 If clr_req=1 and we=1 are sampled together in IDLE, the write SHALL be performed on that edge and the sweep SHALL later zero it.
REQ-028 Reads during CLEAR SHALL return current contents, so registers not yet swept hold their old values.
REQ-029 Holding clr_req high continuously SHALL start a new sweep on the first edge after clr_done.

Reset
REQ-030 rst_n=0 SHALL immediately set all mem entries to 0, registered read_a/read_b to 0, FSM to IDLE, counter to 0, clr_busy=0 and clr_done=0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep with no clr_done pulse.
REQ-032 The first write SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-033 Package reg_bank_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the default DATA_W/ADDR_W constants.
REQ-034 The clear FSM and counter SHALL live in sub-module reg_bank_clr_ctrl, which outputs clr_busy, clr_done, the sweep address and the sweep write strobe; the storage array SHALL stay in reg_bank.

Verification
REQ-035 Defaults: write i*8'h11 to reg i for i = 0..15, then read ra=i, rb=15-i -> read_a = i*8'h11 and read_b = (15-i)*8'h11.
REQ-036 we=0, wa=5, wd=8'h11 after reg 5 holds 8'h55 -> reg 5 still reads 8'h55; then write 8'hAA to reg 3 -> reg 3 reads 8'hAA.
REQ-037 REG_READ=1: same-edge write of 8'h3C to wa=7 with ra=7 -> read_a = 8'h3C one cycle later.
REQ-038 ZERO_REG=1: write 8'hFF to wa=0 -> read_a = 8'h00 for ra=0.
REQ-039 Pulse clr_req after loading all registers -> clr_busy high for 16 cycles, clr_done pulses once, all registers read 0; a we to reg 2 issued mid-sweep is ignored.
REQ-040 Assert rst_n=0 at sweep cycle 8 -> all outputs 0 immediately, no clr_done pulse, and a write after release succeeds.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the reg_bank register file and its
// bulk-clear controller.
package reg_bank_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_bank_clr_ctrl.sv
// Bulk-clear sequencer: walks every address once, emitting a zero-write strobe
// per cycle, then pulses clr_done for one cycle.
module reg_bank_clr_ctrl
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_we,
  output clr_state_e        state
);

  logic [ADDR_W-1:0] cnt;

  // clr_req is only looked at in IDLE, so requests during a sweep are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
      endcase
    end
  end

  assign sweep_addr = cnt;
  assign sweep_we   = (state == CLEAR);

endmodule

// File: rtl/reg_bank.sv
// Two-read, one-write register bank with optional registered reads, optional
// hardwired-zero register 0 and a sweeping bulk-clear.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int REG_READ = 0,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  input  logic              clr_req,
  output logic [DATA_W-1:0] read_a,
  output logic [DATA_W-1:0] read_b,
  output logic              clr_busy,
  output logic              clr_done,
  output clr_state_e        clr_state
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_we;
  logic              user_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  reg_bank_clr_ctrl #(.ADDR_W(ADDR_W)) u_clr_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we),
    .state      (clr_state)
  );

  // The sweep owns the write port while busy; user writes are dropped then.
  assign user_we = we && !clr_busy && !((ZERO_REG != 0) && (wa == '0));
  assign wr_en   = user_we || sweep_we;
  assign wr_addr = sweep_we ? sweep_addr : wa;
  assign wr_data = sweep_we ? '0 : wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // With bypass set, returns the value the entry holds after this edge.
  function automatic logic [DATA_W-1:0] view(input logic [ADDR_W-1:0] addr,
                                             input logic bypass);
    if ((ZERO_REG != 0) && (addr == '0)) return '0;
    if (bypass && wr_en && (wr_addr == addr)) return wr_data;
    return mem[addr];
  endfunction

  if (REG_READ != 0) begin : g_reg_read
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        read_a <= '0;
        read_b <= '0;
      end else begin
        read_a <= view(ra, 1'b1);
        read_b <= view(rb, 1'b1);
      end
    end
  end else begin : g_comb_read
    assign read_a = view(ra, 1'b0);
    assign read_b = view(rb, 1'b0);
  end

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: a default instance and a registered-read/zero-register
// instance share stimulus and are checked against an array-based model.
module tb_reg_bank;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ra, rb, wa;
  logic [7:0] wd;
  logic       we, clr_req;
  logic [7:0] a0, b0, a1, b1;
  logic       busy0, done0, busy1, done1;
  reg_bank_pkg::clr_state_e st0, st1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reg_bank u_dut0 (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .wa(wa), .wd(wd), .we(we),
    .clr_req(clr_req), .read_a(a0), .read_b(b0), .clr_busy(busy0),
    .clr_done(done0), .clr_state(st0)
  );

  reg_bank #(.REG_READ(1), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .wa(wa), .wd(wd), .we(we),
    .clr_req(clr_req), .read_a(a1), .read_b(b1), .clr_busy(busy1),
    .clr_done(done1), .clr_state(st1)
  );

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [DEPTH];
  bit         m_busy, m_done;
  int         m_idx;
  logic [7:0] m_qa, m_qb;

  function automatic logic [7:0] zread(input logic [3:0] a);
    return (a == 4'd0) ? 8'h00 : m_mem[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_busy = 0; m_done = 0; m_idx = 0; m_qa = 8'h00; m_qb = 8'h00;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_mem[m_idx] = 8'h00;
        m_idx++;
        if (m_idx == DEPTH) begin
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        if (we) m_mem[wa] = wd;
        if (clr_req) begin
          m_busy = 1;
          m_idx = 0;
        end
      end
      m_qa = zread(ra);
      m_qb = zread(rb);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("read_a0", a0, m_mem[ra]);
    chk("read_b0", b0, m_mem[rb]);
    chk("read_a1", a1, m_qa);
    chk("read_b1", b1, m_qb);
    chk("busy0", {7'b0, busy0}, {7'b0, m_busy});
    chk("done0", {7'b0, done0}, {7'b0, m_done});
    chk("busy1", {7'b0, busy1}, {7'b0, m_busy});
    chk("done1", {7'b0, done1}, {7'b0, m_done});
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; wa = a; wd = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && busy0; n++) cyc();
    chk("idle_timeout", {7'b0, busy0}, 8'h00);
  endtask

  int busy_cnt, done_cnt;
  bit seen;

  initial begin
    ra = 0; rb = 0; wa = 0; wd = 0; we = 0; clr_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_a0", a0, 8'h00);
    chk("rst_read_a1", a1, 8'h00);
    chk("rst_busy", {7'b0, busy0}, 8'h00);
    rst_n = 1'b1;

    // load i*0x11 then cross-read
    for (int i = 0; i < DEPTH; i++) write(4'(i), 8'(i * 8'h11));
    for (int i = 0; i < DEPTH; i++) begin
      ra = 4'(i); rb = 4'(15 - i);
      #1;
      chk("lit_read_a", a0, 8'(i * 8'h11));
      chk("lit_read_b", b0, 8'(((15 - i) * 8'h11)));
      cyc();
      chk("lit_reg_read_a", a1, (i == 0) ? 8'h00 : 8'(i * 8'h11));
    end

    // disabled write is ignored, enabled write lands
    we = 1'b0; wa = 4'd5; wd = 8'h11;
    cyc();
    ra = 4'd5; #1;
    chk("lit_we0", a0, 8'h55);
    write(4'd3, 8'hAA);
    ra = 4'd3; #1;
    chk("lit_wr3", a0, 8'hAA);

    // same-edge write: bypass only on the registered instance
    ra = 4'd7; we = 1'b1; wa = 4'd7; wd = 8'h3C;
    #1;
    chk("lit_nobypass", a0, 8'h77);
    cyc();
    we = 1'b0;
    chk("lit_bypass", a1, 8'h3C);
    chk("lit_after_wr", a0, 8'h3C);

    // register 0 hardwired on the zero-register instance
    ra = 4'd0; we = 1'b1; wa = 4'd0; wd = 8'hFF;
    cyc();
    we = 1'b0;
    chk("lit_zero_reg", a1, 8'h00);
    chk("lit_reg0_plain", a0, 8'hFF);

    // clear sweep with a write issued mid-sweep
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy0) busy_cnt++;
      if (done0) done_cnt++;
      if (n == 5) begin we = 1'b1; wa = 4'd2; wd = 8'h5A; end
      else we = 1'b0;
      cyc();
    end
    chk("lit_busy_cycles", 8'(busy_cnt), 8'd16);
    chk("lit_done_pulses", 8'(done_cnt), 8'd1);
    for (int i = 0; i < DEPTH; i++) begin
      ra = 4'(i); #1;
      chk("lit_cleared", a0, 8'h00);
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      wd = 8'($urandom_range(0, 255));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 19) == 0);
      cyc();
    end
    we = 1'b0; clr_req = 1'b0;
    wait_idle();

    // held request restarts right after clr_done
    clr_req = 1'b1;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      cyc();
      if (done0) seen = 1;
    end
    chk("held_done_seen", {7'b0, seen}, 8'h01);
    cyc();
    chk("lit_restart", {7'b0, busy0}, 8'h01);
    clr_req = 1'b0;
    wait_idle();
    cyc();

    // reset mid-sweep
    for (int i = 0; i < DEPTH; i++) write(4'(i), 8'($urandom_range(1, 255)));
    ra = 4'd12; rb = 4'd13;
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (8) cyc();
    rst_n = 1'b0;
    #1;
    chk("lit_rst_a0", a0, 8'h00);
    chk("lit_rst_b0", b0, 8'h00);
    chk("lit_rst_a1", a1, 8'h00);
    chk("lit_rst_b1", b1, 8'h00);
    chk("lit_rst_busy", {7'b0, busy0}, 8'h00);
    chk("lit_rst_done", {7'b0, done0}, 8'h00);
    repeat (2) cyc();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (done0 || done1) done_cnt++;
      cyc();
    end
    chk("lit_no_done_after_rst", 8'(done_cnt), 8'd0);
    write(4'd9, 8'hC3);
    ra = 4'd9; #1;
    chk("lit_write_after_rst", a0, 8'hC3);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
